dtim_assoc: RTL and testbench
=============================

DTIM_ASSOC -- requirements
Module: dtim_assoc

Interface
REQ-001 Parameter SETS, default 64, number of sets; power of two, at least 2.
REQ-002 Parameter WAYS, default 2, associativity; one of 1, 2, 4.
REQ-003 Parameter BASE_ADDR, default 32'h0010_0000, lowest cacheable byte address (inclusive).
REQ-004 Parameter TOP_ADDR, default 32'h0020_0000, cacheable upper bound (exclusive).
REQ-005 Port clock, input, 1, sole clock; all state SHALL update on its rising edge.
REQ-006 Port reset, input, 1, one clock; reset is asynchronous and active-low.
REQ-007 Ports dtim_valid (in, 1) and dtim_fence (in, 1): request strobe and flush request.
REQ-008 Ports dtim_addr (in, 32), dtim_wdata (in, 32) and dtim_wstrb (in, 4): request address, store data and byte strobes; a wstrb of 0 means a load.
REQ-009 Ports dtim_rdata (out, 32) and dtim_ready (out, 1): response data and single-cycle completion pulse.
REQ-010 Ports dmem_valid (out, 1), dmem_addr (out, 32), dmem_wdata (out, 32) and dmem_wstrb (out, 4): backing-memory request.
REQ-011 Ports dmem_rdata (in, 32) and dmem_ready (in, 1): backing-memory response.

Function
REQ-012 Each line SHALL hold one 32-bit word with valid, dirty and tag bits.
- index = addr[log2(SETS)+1:2]
- tag = addr[31:log2(SETS)+2]
- storage SHALL be internal.
REQ-013 Each set SHALL keep a log2(WAYS)-bit round-robin victim pointer.
- The pointer advances by 1 modulo WAYS on each fill into that set.
- The fill SHALL use an invalid way (lowest index) ahead of the pointer.
REQ-014 States SHALL be IDLE, LOOKUP, EVICT, FILL, BYPASS and FLUSH. A request is accepted only in IDLE with dtim_valid=1; dtim_valid is ignored in every other state.
REQ-015 On acceptance, the address, data, strobe and fence fields SHALL be registered and the state SHALL move to LOOKUP on the next edge.
REQ-016 LOOKUP SHALL branch with this priority: fence to FLUSH, then address outside [BASE_ADDR, TOP_ADDR) to BYPASS, then hit to IDLE, then miss with a dirty victim to EVICT, then miss with a clean victim to FILL.
REQ-017 Load hit:
- dtim_ready=1 in the LOOKUP cycle (2 cycles after acceptance), with dtim_rdata equal to the line word.
REQ-018 Store hit:
- Merge the strobed bytes into the line and set dirty.
- dtim_ready=1 in the LOOKUP cycle, with dtim_rdata=0.
REQ-019 EVICT: dmem_valid=1, dmem_addr={victim tag, index, 2'b00}, dmem_wdata=victim word, dmem_wstrb=4'hF. When dmem_ready=1, move to FILL.
REQ-020 FILL: dmem_valid=1, dmem_addr={addr[31:2],2'b00}, dmem_wstrb=0. When dmem_ready=1:
- Install the line with valid=1 and the new tag.
- For a store, merge the strobed bytes into dmem_rdata and set dirty=1.
- Drive dtim_ready=1 in that same cycle, with dtim_rdata=dmem_rdata for a load and 0 for a store.
- Return to IDLE.
REQ-021 BYPASS: forward the address with [1:0] forced to 0, the data and the strobe to dmem. When dmem_ready=1, pass dmem_rdata through, drive dtim_ready=1 and return to IDLE. Cache state SHALL be unchanged.
REQ-022 While dmem_valid=1, dmem_addr, dmem_wdata and dmem_wstrb SHALL stay stable until dmem_ready=1. dmem_valid SHALL be 0 in IDLE and LOOKUP.
REQ-023 FLUSH SHALL visit the ways in order: set-major, way-minor, from set 0/way 0 up to SETS-1/WAYS-1.
- A line that is valid and dirty is written back as in REQ-019, and the walk waits for dmem_ready.
- Any other line costs one cycle.
- Each visited line SHALL be invalidated.
- After the last line: dtim_ready=1, all victim pointers cleared, then IDLE.
REQ-024 dtim_ready SHALL be a single-cycle pulse, exactly one per accepted request. dtim_rdata SHALL be 0 whenever dtim_ready=0.
REQ-025 A dmem_ready seen outside EVICT, FILL, BYPASS or a FLUSH write-back SHALL be ignored.

Reset
REQ-026 While reset=0, these SHALL be forced immediately, at any state or mid-transaction:
- state=IDLE
- all valid, dirty and victim pointers=0
- dtim_ready=0, dtim_rdata=0
- dmem_valid=0, dmem_addr=0, dmem_wdata=0, dmem_wstrb=0
REQ-027 After reset, the first dtim_valid SHALL be accepted on the first rising edge with reset=1. Dirty data lost by reset SHALL NOT be written back.

Verification (SETS=4, WAYS=2, dmem_ready 3 cycles after dmem_valid)
REQ-028 Cold load from 0x0010_0010 (set 0) -> one FILL read at 0x0010_0010, then dtim_ready with the memory data; a repeat load hits with dtim_ready 2 cycles after acceptance and no dmem_valid.
REQ-029 Store 0xAABBCCDD with wstrb=4'b0011 to a hit line holding 0x11223344 -> line becomes 0x1122CCDD and dirty; a following load returns 0x1122CCDD.
REQ-030 Dirty lines at 0x0010_0000 and 0x0010_0010 (set 0), then a load of 0x0010_0020 -> EVICT write of way 0 (0x0010_0000, wstrb 4'hF), then a FILL read of 0x0010_0020; the victim pointer of set 0 becomes 1.
REQ-031 Load from 0x0030_0004 -> BYPASS read at 0x0030_0004; cache contents unchanged.
REQ-032 Fence with 3 dirty lines -> exactly 3 dmem writes in set/way order, then one dtim_ready; all lines invalid afterwards.
REQ-033 reset=0 asserted in the middle of EVICT -> dmem_valid=0 with no clock edge; after release, a load of the same address misses and fills with no write-back.

Source files
------------

// File: rtl/dtim_assoc.sv
// dtim_assoc -- set-associative, write-back data cache with one 32-bit word
// per line, sitting between a simple request port (dtim_*) and a backing
// memory port (dmem_*).
//
// Ports
//   clock, reset             : sole clock (rising edge); asynchronous active-low reset
//   dtim_valid, dtim_fence   : request strobe; flush request (write back and invalidate all)
//   dtim_addr, dtim_wdata    : request byte address and store data
//   dtim_wstrb               : byte strobes, 4'b0000 means a load
//   dtim_rdata, dtim_ready   : response data and one-cycle completion pulse
//   dmem_valid, dmem_addr,
//   dmem_wdata, dmem_wstrb   : backing-memory request (wstrb 0 = read)
//   dmem_rdata, dmem_ready   : backing-memory response
//
// Addresses outside [BASE_ADDR, TOP_ADDR) bypass the cache untouched.
module dtim_assoc #(
  parameter int          SETS      = 64,
  parameter int          WAYS      = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0010_0000,
  parameter logic [31:0] TOP_ADDR  = 32'h0020_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dtim_valid,
  input  logic        dtim_fence,
  input  logic [31:0] dtim_addr,
  input  logic [31:0] dtim_wdata,
  input  logic [3:0]  dtim_wstrb,
  output logic [31:0] dtim_rdata,
  output logic        dtim_ready,
  output logic        dmem_valid,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready
);

  localparam int IDXW = $clog2(SETS);
  localparam int WAYW = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int TAGW = 30 - IDXW;

  typedef enum logic [2:0] {IDLE, LOOKUP, EVICT, FILL, BYPASS, FLUSH} state_t;
  state_t state_reg, state_next;

  // Registered request
  logic [31:0]     addr_reg, wdata_reg;
  logic [3:0]      wstrb_reg;
  logic            fence_reg;
  logic [WAYW-1:0] victim_reg;
  logic [IDXW-1:0] flush_set_reg;
  logic [WAYW-1:0] flush_way_reg;

  // Line state (reset-cleared) and line contents (no reset needed: a line is
  // only ever read while its valid bit is set)
  logic            valid_reg [SETS][WAYS];
  logic            dirty_reg [SETS][WAYS];
  logic [WAYW-1:0] ptr_reg   [SETS];
  logic [TAGW-1:0] tag_mem   [SETS][WAYS];
  logic [31:0]     data_mem  [SETS][WAYS];

  logic [IDXW-1:0] req_idx;
  logic [TAGW-1:0] req_tag;
  logic            req_store, in_range;

  assign req_idx   = addr_reg[IDXW+1:2];
  assign req_tag   = addr_reg[31:IDXW+2];
  assign req_store = |wstrb_reg;
  assign in_range  = (addr_reg >= BASE_ADDR) && (addr_reg < TOP_ADDR);

  logic [WAYS-1:0] hit_vec;
  for (genvar gi = 0; gi < WAYS; gi++) begin : g_hit
    assign hit_vec[gi] = valid_reg[req_idx][gi] && (tag_mem[req_idx][gi] == req_tag);
  end

  // Hit way, and victim = lowest invalid way, else the round-robin pointer
  logic [WAYW-1:0] hit_way, victim_way;
  always_comb begin
    hit_way    = '0;
    victim_way = ptr_reg[req_idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) hit_way = WAYW'(w);
      if (!valid_reg[req_idx][w]) victim_way = WAYW'(w);
    end
  end

  logic flush_last;
  assign flush_last = (flush_set_reg == IDXW'(SETS - 1)) && (flush_way_reg == WAYW'(WAYS - 1));

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    end
    return res;
  endfunction

  // Line-install controls shared by the store-hit and fill paths
  logic            mem_we, mem_dirty, fill_done, flush_step, flush_done;
  logic [WAYW-1:0] mem_way;
  logic [31:0]     mem_data;

  always_comb begin
    state_next = state_reg;
    dtim_ready = 1'b0;
    dtim_rdata = '0;
    dmem_valid = 1'b0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    dmem_wstrb = '0;
    mem_we     = 1'b0;
    mem_dirty  = 1'b0;
    mem_way    = hit_way;
    mem_data   = '0;
    fill_done  = 1'b0;
    flush_step = 1'b0;
    flush_done = 1'b0;
    case (state_reg)
      IDLE: begin
        if (dtim_valid) state_next = LOOKUP;
      end
      LOOKUP: begin
        if (fence_reg) begin
          state_next = FLUSH;
        end else if (!in_range) begin
          state_next = BYPASS;
        end else if (|hit_vec) begin
          dtim_ready = 1'b1;
          state_next = IDLE;
          if (req_store) begin
            mem_we    = 1'b1;
            mem_dirty = 1'b1;
            mem_data  = merge_bytes(data_mem[req_idx][hit_way], wdata_reg, wstrb_reg);
          end else begin
            dtim_rdata = data_mem[req_idx][hit_way];
          end
        end else if (valid_reg[req_idx][victim_way] && dirty_reg[req_idx][victim_way]) begin
          state_next = EVICT;
        end else begin
          state_next = FILL;
        end
      end
      EVICT: begin
        dmem_valid = 1'b1;
        dmem_addr  = {tag_mem[req_idx][victim_reg], req_idx, 2'b00};
        dmem_wdata = data_mem[req_idx][victim_reg];
        dmem_wstrb = 4'hF;
        if (dmem_ready) state_next = FILL;
      end
      FILL: begin
        dmem_valid = 1'b1;
        dmem_addr  = {addr_reg[31:2], 2'b00};
        if (dmem_ready) begin
          mem_we     = 1'b1;
          mem_way    = victim_reg;
          mem_dirty  = req_store;
          mem_data   = req_store ? merge_bytes(dmem_rdata, wdata_reg, wstrb_reg) : dmem_rdata;
          fill_done  = 1'b1;
          dtim_ready = 1'b1;
          dtim_rdata = req_store ? 32'h0 : dmem_rdata;
          state_next = IDLE;
        end
      end
      BYPASS: begin
        dmem_valid = 1'b1;
        dmem_addr  = {addr_reg[31:2], 2'b00};
        dmem_wdata = wdata_reg;
        dmem_wstrb = wstrb_reg;
        if (dmem_ready) begin
          dtim_ready = 1'b1;
          dtim_rdata = dmem_rdata;
          state_next = IDLE;
        end
      end
      FLUSH: begin
        if (valid_reg[flush_set_reg][flush_way_reg] && dirty_reg[flush_set_reg][flush_way_reg]) begin
          dmem_valid = 1'b1;
          dmem_addr  = {tag_mem[flush_set_reg][flush_way_reg], flush_set_reg, 2'b00};
          dmem_wdata = data_mem[flush_set_reg][flush_way_reg];
          dmem_wstrb = 4'hF;
          flush_step = dmem_ready;
        end else begin
          flush_step = 1'b1;
        end
        if (flush_step && flush_last) begin
          flush_done = 1'b1;
          dtim_ready = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      wstrb_reg     <= '0;
      fence_reg     <= 1'b0;
      victim_reg    <= '0;
      flush_set_reg <= '0;
      flush_way_reg <= '0;
      for (int s = 0; s < SETS; s++) begin
        ptr_reg[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          valid_reg[s][w] <= 1'b0;
          dirty_reg[s][w] <= 1'b0;
        end
      end
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && dtim_valid) begin
        addr_reg      <= dtim_addr;
        wdata_reg     <= dtim_wdata;
        wstrb_reg     <= dtim_wstrb;
        fence_reg     <= dtim_fence;
        flush_set_reg <= '0;
        flush_way_reg <= '0;
      end
      if (state_reg == LOOKUP) victim_reg <= victim_way;
      if (mem_we) begin
        valid_reg[req_idx][mem_way] <= 1'b1;
        dirty_reg[req_idx][mem_way] <= mem_dirty;
      end
      if (fill_done) begin
        ptr_reg[req_idx] <= (ptr_reg[req_idx] == WAYW'(WAYS - 1)) ? '0 : ptr_reg[req_idx] + 1'b1;
      end
      if (flush_step) begin
        valid_reg[flush_set_reg][flush_way_reg] <= 1'b0;
        dirty_reg[flush_set_reg][flush_way_reg] <= 1'b0;
        if (flush_way_reg == WAYW'(WAYS - 1)) begin
          flush_way_reg <= '0;
          flush_set_reg <= flush_set_reg + 1'b1;
        end else begin
          flush_way_reg <= flush_way_reg + 1'b1;
        end
      end
      if (flush_done) begin
        for (int s = 0; s < SETS; s++) ptr_reg[s] <= '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      tag_mem[req_idx][mem_way]  <= req_tag;
      data_mem[req_idx][mem_way] <= mem_data;
    end
  end

endmodule

// File: tb/tb_dtim_assoc.sv
// Testbench for dtim_assoc (SETS=4, WAYS=2). Stimulus pushes the expected
// response word and the expected backing-memory transactions into queues;
// a monitor pops and compares them whenever the DUT completes a request or
// a memory handshake. The backing memory answers 3 cycles after dmem_valid.
module tb_dtim_assoc;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        dtim_valid = 1'b0, dtim_fence = 1'b0;
  logic [31:0] dtim_addr = '0, dtim_wdata = '0;
  logic [3:0]  dtim_wstrb = '0;
  logic [31:0] dtim_rdata;
  logic        dtim_ready;
  logic        dmem_valid;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_rdata = '0;
  logic        dmem_ready = 1'b0;

  always #5 clock = ~clock;

  dtim_assoc #(.SETS(4), .WAYS(2)) dut (
    .clock(clock), .reset(reset),
    .dtim_valid(dtim_valid), .dtim_fence(dtim_fence), .dtim_addr(dtim_addr),
    .dtim_wdata(dtim_wdata), .dtim_wstrb(dtim_wstrb),
    .dtim_rdata(dtim_rdata), .dtim_ready(dtim_ready),
    .dmem_valid(dmem_valid), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } dm_t;

  logic [31:0] exp_rd_q[$];
  dm_t         dm_q[$];
  logic [31:0] mem [logic [31:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'hDEAD_BEEF;
  endfunction

  // Backing memory: ready (with data for reads) after 3 cycles of dmem_valid
  int   mcnt = 0;
  dm_t  cur;
  always @(posedge clock) begin
    #1;
    if (!reset) begin
      mcnt = 0; dmem_ready = 1'b0; dmem_rdata = '0;
    end else if (dmem_ready) begin
      if (cur.wstrb != 4'h0) begin
        logic [31:0] w;
        w = mem_rd(cur.addr);
        for (int b = 0; b < 4; b++) if (cur.wstrb[b]) w[8*b +: 8] = cur.wdata[8*b +: 8];
        mem[cur.addr] = w;
      end
      dmem_ready = 1'b0; dmem_rdata = '0; mcnt = 0;
    end else if (dmem_valid) begin
      mcnt++;
      if (mcnt == 3) begin
        cur = '{dmem_addr, dmem_wdata, dmem_wstrb};
        dmem_ready = 1'b1;
        dmem_rdata = (dmem_wstrb == 4'h0) ? mem_rd(dmem_addr) : 32'h0;
      end
    end else begin
      mcnt = 0;
    end
  end

  // Monitor: compares every completion and every memory handshake
  always @(negedge clock) begin
    if (reset) begin
      if (dtim_ready) begin
        if (exp_rd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_dtim_ready: got rdata %h expected no response", dtim_rdata);
        end else begin
          check("dtim_rdata", dtim_rdata, exp_rd_q.pop_front());
        end
      end else begin
        check("rdata_idle_zero", dtim_rdata, 32'h0);
      end
      if (dmem_valid && dmem_ready) begin
        if (dm_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_dmem: got addr %h wstrb %h expected no transaction", dmem_addr, dmem_wstrb);
        end else begin
          dm_t e;
          e = dm_q.pop_front();
          check("dmem_addr", dmem_addr, e.addr);
          check("dmem_wstrb", {28'h0, dmem_wstrb}, {28'h0, e.wstrb});
          if (e.wstrb != 4'h0) check("dmem_wdata", dmem_wdata, e.wdata);
        end
      end
    end
  end

  task automatic exp_dmem(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
    dm_q.push_back('{a, wd, ws});
  endtask

  // exp_lat > 0 marks a hit: latency (cycles from presenting dtim_valid) and
  // absence of dmem_valid are also checked.
  task automatic do_req(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                        input logic fn, input logic [31:0] exp_rd, input int exp_lat);
    int  n;
    bit  done, saw_dmem;
    exp_rd_q.push_back(exp_rd);
    @(negedge clock);
    dtim_valid = 1'b1; dtim_addr = a; dtim_wdata = wd; dtim_wstrb = ws; dtim_fence = fn;
    @(posedge clock);
    #1 dtim_valid = 1'b0; dtim_fence = 1'b0;
    n = 0; done = 0; saw_dmem = 0;
    while (!done && n < 300) begin
      @(negedge clock);
      n++;
      if (dmem_valid) saw_dmem = 1;
      if (dtim_ready) done = 1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL req_timeout: addr %h got no dtim_ready expected one within 300 cycles", a);
    end
    $display("req addr=%h wdata=%h wstrb=%h fence=%0d exp_rdata=%h cycles=%0d", a, wd, ws, fn, exp_rd, n + 1);
    if (exp_lat > 0) begin
      check("hit_latency", 32'(n + 1), 32'(exp_lat));
      check("hit_no_dmem", {31'h0, saw_dmem}, 32'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    mem[32'h0010_0000] = 32'hA0A0_A0A0;
    mem[32'h0010_0010] = 32'h1122_3344;
    mem[32'h0010_0020] = 32'h2222_2222;
    mem[32'h0010_0030] = 32'h3333_3333;
    mem[32'h0010_0004] = 32'h4444_4444;
    mem[32'h0010_0008] = 32'h8888_8888;
    mem[32'h0030_0004] = 32'h3030_3030;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_dtim_ready", {31'h0, dtim_ready}, 32'h0);
    check("rst_dtim_rdata", dtim_rdata, 32'h0);
    check("rst_dmem_valid", {31'h0, dmem_valid}, 32'h0);
    check("rst_dmem_addr", dmem_addr, 32'h0);
    check("rst_dmem_wdata", dmem_wdata, 32'h0);
    check("rst_dmem_wstrb", {28'h0, dmem_wstrb}, 32'h0);
    reset = 1'b1;

    // Cold load, hit, partial store hit, reload
    exp_dmem(32'h0010_0010, 32'h0, 4'h0);
    do_req(32'h0010_0010, 32'h0, 4'h0, 1'b0, 32'h1122_3344, 0);
    do_req(32'h0010_0010, 32'h0, 4'h0, 1'b0, 32'h1122_3344, 2);
    do_req(32'h0010_0010, 32'hAABB_CCDD, 4'b0011, 1'b0, 32'h0, 2);
    do_req(32'h0010_0010, 32'h0, 4'h0, 1'b0, 32'h1122_CCDD, 2);

    // Store misses (write-allocate) in sets 1 and 2
    exp_dmem(32'h0010_0004, 32'h0, 4'h0);
    do_req(32'h0010_0004, 32'h1234_5678, 4'hF, 1'b0, 32'h0, 0);
    exp_dmem(32'h0010_0008, 32'h0, 4'h0);
    do_req(32'h0010_0008, 32'h9ABC_DEF0, 4'hF, 1'b0, 32'h0, 0);

    // Fence with 3 dirty lines: write-backs in set/way order
    exp_dmem(32'h0010_0010, 32'h1122_CCDD, 4'hF);
    exp_dmem(32'h0010_0004, 32'h1234_5678, 4'hF);
    exp_dmem(32'h0010_0008, 32'h9ABC_DEF0, 4'hF);
    do_req(32'h0, 32'h0, 4'h0, 1'b1, 32'h0, 0);
    // Lines are invalid now: miss, data comes back from the written-back copy
    exp_dmem(32'h0010_0004, 32'h0, 4'h0);
    do_req(32'h0010_0004, 32'h0, 4'h0, 1'b0, 32'h1234_5678, 0);

    // Two dirty lines in set 0, then conflict misses
    exp_dmem(32'h0010_0000, 32'h0, 4'h0);
    do_req(32'h0010_0000, 32'h0, 4'h0, 1'b0, 32'hA0A0_A0A0, 0);
    exp_dmem(32'h0010_0010, 32'h0, 4'h0);
    do_req(32'h0010_0010, 32'h0, 4'h0, 1'b0, 32'h1122_CCDD, 0);
    do_req(32'h0010_0000, 32'h0000_00FF, 4'b0001, 1'b0, 32'h0, 2);
    do_req(32'h0010_0010, 32'h7700_0000, 4'b1000, 1'b0, 32'h0, 2);
    exp_dmem(32'h0010_0000, 32'hA0A0_A0FF, 4'hF);
    exp_dmem(32'h0010_0020, 32'h0, 4'h0);
    do_req(32'h0010_0020, 32'h0, 4'h0, 1'b0, 32'h2222_2222, 0);
    // Pointer now 1: way 1 (0x0010_0010) is the next victim
    exp_dmem(32'h0010_0010, 32'h7722_CCDD, 4'hF);
    exp_dmem(32'h0010_0030, 32'h0, 4'h0);
    do_req(32'h0010_0030, 32'h0, 4'h0, 1'b0, 32'h3333_3333, 0);

    // Bypass and range boundaries
    exp_dmem(32'h0030_0004, 32'h0, 4'h0);
    do_req(32'h0030_0004, 32'h0, 4'h0, 1'b0, 32'h3030_3030, 0);
    exp_dmem(32'h0030_0004, 32'h0, 4'h0);
    do_req(32'h0030_0007, 32'h0, 4'h0, 1'b0, 32'h3030_3030, 0);
    exp_dmem(32'h0030_0008, 32'hCAFE_F00D, 4'b0110);
    do_req(32'h0030_0008, 32'hCAFE_F00D, 4'b0110, 1'b0, 32'h0, 0);
    exp_dmem(32'h0020_0000, 32'h0, 4'h0);
    do_req(32'h0020_0000, 32'h0, 4'h0, 1'b0, 32'hDEAD_BEEF, 0);
    exp_dmem(32'h000F_FFFC, 32'h0, 4'h0);
    do_req(32'h000F_FFFC, 32'h0, 4'h0, 1'b0, 32'hDEAD_BEEF, 0);
    exp_dmem(32'h001F_FFFC, 32'h0, 4'h0);
    do_req(32'h001F_FFFC, 32'h0, 4'h0, 1'b0, 32'hDEAD_BEEF, 0);
    do_req(32'h0010_0020, 32'h0, 4'h0, 1'b0, 32'h2222_2222, 2);

    // Reset in the middle of an eviction
    do_req(32'h0010_0020, 32'h0BAD_F00D, 4'hF, 1'b0, 32'h0, 2);
    begin
      int n;
      @(negedge clock);
      dtim_valid = 1'b1; dtim_addr = 32'h0010_0040; dtim_wdata = '0; dtim_wstrb = '0;
      @(posedge clock);
      #1 dtim_valid = 1'b0;
      n = 0;
      while (!dmem_valid && n < 20) begin @(negedge clock); n++; end
      check("evict_addr", dmem_addr, 32'h0010_0020);
      check("evict_wstrb", {28'h0, dmem_wstrb}, 32'hF);
      @(posedge clock);
      #3 reset = 1'b0;
      #1;
      check("mid_rst_dmem_valid", {31'h0, dmem_valid}, 32'h0);
      check("mid_rst_dmem_addr", dmem_addr, 32'h0);
      check("mid_rst_dmem_wdata", dmem_wdata, 32'h0);
      check("mid_rst_dtim_ready", {31'h0, dtim_ready}, 32'h0);
      $display("reset asserted during eviction of addr=%h", 32'h0010_0020);
      repeat (2) @(negedge clock);
      reset = 1'b1;
    end
    exp_dmem(32'h0010_0020, 32'h0, 4'h0);
    do_req(32'h0010_0020, 32'h0, 4'h0, 1'b0, 32'h2222_2222, 0);

    repeat (8) @(negedge clock);
    check("rdata_queue_empty", 32'(exp_rd_q.size()), 32'h0);
    check("dmem_queue_empty", 32'(dm_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
